lfsr_updown_checker: RTL and testbench
======================================

# lfsr_updown_checker

Self-checking monitor for the up/down LFSR counter. It samples the counter's `enable`, `up_down` and `count` every clock, predicts the next `count` from the same feedback rule, and acquires lock on the incoming sequence. Once locked it flags and counts mismatches and drops lock after repeated errors. It sits beside the counter in benches and in the BIST wrapper, as the reading end of the counter's output interface.

## Interface
- `WIDTH`, 8, counter width; must match the generator; ≥ 3.
- `TAPS`, 8'b1011_1000, feedback tap mask; bit `WIDTH-1` must be 1.
- `LOCK_CNT`, 4, consecutive correct predictions needed to declare lock; 1..15.
- `MAX_ERR`, 3, consecutive mismatches while locked that force loss of lock; 1..15.
- `clk`  input  1  single clock; all sampling on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `enable`  input  1  generator step enable, sampled.
- `up_down`  input  1  generator direction, sampled; 0 = up, 1 = down.
- `count`  input  WIDTH  generator output, sampled.
- `locked`  output  1  sequence lock held.
- `mismatch`  output  1  one-cycle pulse; prediction failed while locked.
- `lost_lock`  output  1  one-cycle pulse on the LOCKED→ACQUIRE transition.
- `lockup`  output  1  sticky; `count` was seen all-ones (XNOR lockup state).
- `err_count`  output  16  mismatches counted while locked; saturates at 16'hFFFF.

## Operation
- Step functions, with c the current value:
  - Up: `{c[WIDTH-2:0], ~^(c & TAPS)}`.
  - Down, the exact inverse: `{~(c[0] ^ ^(c[WIDTH-1:1] & TAPS[WIDTH-2:0])), c[WIDTH-1:1]}`.
  - Default taps give a 255-state sequence; all-ones is excluded.
- Sample registers hold the previous cycle's `count`, `enable` and `up_down`.
- Expected value for this cycle:
  - If the registered `enable` is 0: equals the registered `count`.
  - Otherwise: step(registered `count`, registered `up_down`).
- Match means `count` equals the expected value.
- States:
  - RESET_WAIT: entered while `reset`=0. On the first cycle after `reset`=1, only sample; no compare. Go to ACQUIRE.
  - ACQUIRE: a match increments `good_cnt`; a miss clears it. When `good_cnt` reaches `LOCK_CNT`, go to LOCKED and assert `locked`. Mismatches are not counted here.
  - LOCKED: a miss pulses `mismatch`, increments `err_count` (saturating) and increments `bad_cnt`; a match clears `bad_cnt`. When `bad_cnt` reaches `MAX_ERR`, pulse `lost_lock`, clear `locked` and `good_cnt`, and go to ACQUIRE.
- ACQUIRE always re-seeds from live samples, so the checker relocks after the generator is reset or reloaded.
- `lockup` sets in any state other than RESET_WAIT when the sampled `count` is all-ones. It clears only on reset.
- Reset (`reset`=0 at an edge) applies in every state, mid-operation included:
  - Outputs: `locked`=0, `mismatch`=0, `lost_lock`=0, `lockup`=0, `err_count`=0.
  - Internal: `good_cnt`=0, `bad_cnt`=0, sample registers=0, state RESET_WAIT.

## Timing
- All outputs are registered.
- `mismatch` asserts on the edge after the bad `count` is sampled: 1-cycle latency, high for exactly 1 cycle per bad sample.
- `locked` rises on the edge that scores the `LOCK_CNT`-th consecutive match.
  - From reset release with a clean stream: 1 sample cycle + `LOCK_CNT` cycles.
- On the MAX_ERR-th miss, in the same cycle: `mismatch`=1, `lost_lock`=1, `locked` falls.
- Direction changes and enable toggles are legal on any cycle. Prediction always uses the previous cycle's control, matching the generator's registered update.
- Simultaneous events:
  - `err_count` at 16'hFFFF with a new miss: holds, `mismatch` still pulses.
  - A match and a lock threshold reached in the same cycle: the threshold wins.
- Wrap-around: the up step from the last sequence state returns to the first; a step down from 0 gives `8'h80` with default taps. Both are ordinary matches.

## Test plan
- Reset 10 cycles; release; `enable`=1, `up_down`=0 with a golden generator from 0 → `locked`=1 by cycle 5 after release; `err_count`=0 after 300 cycles, covering a full 255-state wrap.
- Locked, up 20 cycles, then `up_down`=1 for 30 cycles, then `enable`=0 for 5 cycles → no `mismatch`; stream of 0→01→03→07… reversing exactly.
- Locked; force `count` to 8'h5A for one cycle → one `mismatch` pulse, `err_count`=1; a second forced miss → `err_count`=2, `locked` stays 1.
- Locked; 3 consecutive corrupted samples → `lost_lock` pulse on the third; `err_count`=3; clean stream resumes → `locked` back after 4 matches.
- Drive `count`=8'hFF for one cycle → `lockup`=1 and stays after clean traffic; pulse `reset`=0 for one cycle mid-stream → all outputs 0 on the next edge; relock follows.
- Preload `err_count` via 65 540 forced misses with `MAX_ERR`=15 and interleaved matches → saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/lfsr_updown_checker.sv
// Monitor for the up/down LFSR counter: predicts each sampled count from the
// previous cycle's sample and control, acquires lock and scores mismatches.
module lfsr_updown_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'b1011_1000,
    parameter int               LOCK_CNT = 4,
    parameter int               MAX_ERR  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             mismatch,
    output logic             lost_lock,
    output logic             lockup,
    output logic [15:0]      err_count
);

    typedef enum logic [1:0] {
        RESET_WAIT,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_LIM  = 4'(MAX_ERR);

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
        return {c[WIDTH-2:0], ~^(c & TAPS)};
    endfunction

    // Exact inverse of step_up: recovers the bit that was shifted out the top.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
        return {~(c[0] ^ (^(c[WIDTH-1:1] & TAPS[WIDTH-2:0]))), c[WIDTH-1:1]};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] samp_count;
    logic             samp_enable, samp_up_down;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             locked_d, mismatch_d, lost_lock_d, lockup_d;
    logic [15:0]      err_d;
    logic [WIDTH-1:0] expected;
    logic             match;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        locked_d    = locked;
        mismatch_d  = 1'b0;
        lost_lock_d = 1'b0;
        err_d       = err_count;
        lockup_d    = lockup | ((state_q != RESET_WAIT) && (&count));

        if (!samp_enable)      expected = samp_count;
        else if (samp_up_down) expected = step_down(samp_count);
        else                   expected = step_up(samp_count);
        match = (count == expected);

        case (state_q)
            RESET_WAIT: begin
                state_d = ACQUIRE;
                good_d  = '0;
                bad_d   = '0;
            end
            ACQUIRE: begin
                if (!match) begin
                    good_d = '0;
                end else if (good_q + 4'd1 == LOCK_LIM) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    good_d   = '0;
                    bad_d    = '0;
                end else begin
                    good_d = good_q + 4'd1;
                end
            end
            LOCKED: begin
                if (match) begin
                    bad_d = '0;
                end else begin
                    mismatch_d = 1'b1;
                    if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
                    if (bad_q + 4'd1 == ERR_LIM) begin
                        lost_lock_d = 1'b1;
                        locked_d    = 1'b0;
                        good_d      = '0;
                        bad_d       = '0;
                        state_d     = ACQUIRE;
                    end else begin
                        bad_d = bad_q + 4'd1;
                    end
                end
            end
            default: state_d = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RESET_WAIT;
            samp_count   <= '0;
            samp_enable  <= 1'b0;
            samp_up_down <= 1'b0;
            good_q       <= '0;
            bad_q        <= '0;
            locked       <= 1'b0;
            mismatch     <= 1'b0;
            lost_lock    <= 1'b0;
            lockup       <= 1'b0;
            err_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q      <= state_d;
            samp_count   <= count;
            samp_enable  <= enable;
            samp_up_down <= up_down;
            good_q       <= good_d;
            bad_q        <= bad_d;
            locked       <= locked_d;
            mismatch     <= mismatch_d;
            lost_lock    <= lost_lock_d;
            lockup       <= lockup_d;
            err_count    <= err_d;
        end
    end

endmodule

// File: tb/tb_lfsr_updown_checker.sv
// Scoreboard bench for lfsr_updown_checker: a golden generator drives count,
// expected outputs are queued per edge and a monitor pops and compares them.
module tb_lfsr_updown_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, up_down;
    logic [7:0]  count;
    logic        locked, mismatch, lost_lock, lockup;
    logic [15:0] err_count;

    logic        rst2, en2, ud2;
    logic [7:0]  cnt2;
    logic        locked2, mismatch2, lost_lock2, lockup2;
    logic [15:0] err2;

    lfsr_updown_checker #(.WIDTH(8), .TAPS(8'b1011_1000), .LOCK_CNT(4), .MAX_ERR(3)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .count(count),
        .locked(locked), .mismatch(mismatch), .lost_lock(lost_lock), .lockup(lockup),
        .err_count(err_count)
    );

    lfsr_updown_checker #(.WIDTH(8), .TAPS(8'b1011_1000), .LOCK_CNT(4), .MAX_ERR(15)) u_sat (
        .clk(clk), .reset(rst2), .enable(en2), .up_down(ud2), .count(cnt2),
        .locked(locked2), .mismatch(mismatch2), .lost_lock(lost_lock2), .lockup(lockup2),
        .err_count(err2)
    );

    typedef struct packed {
        logic        locked;
        logic        mismatch;
        logic        lost_lock;
        logic        lockup;
        logic [15:0] err;
    } resp_t;

    resp_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  gen;
    logic        exp_lockup;
    logic [15:0] exp_err;

    // Golden generator, written bitwise from the tap positions 7,5,4,3.
    function automatic logic [7:0] g_up(input logic [7:0] c);
        return {c[6:0], ~(c[7] ^ c[5] ^ c[4] ^ c[3])};
    endfunction

    function automatic logic [7:0] g_dn(input logic [7:0] c);
        return {~(c[0] ^ c[6] ^ c[5] ^ c[4]), c[7:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of generator traffic; ld replaces the generator state (reload).
    task automatic drive(input logic en, input logic ud, input logic ld, input logic [7:0] ld_val,
                         input logic e_lk, input logic e_mm, input logic e_ll);
        resp_t r;
        @(negedge clk);
        reset   = 1'b1;
        enable  = en;
        up_down = ud;
        if (ld) gen = ld_val;
        count = gen;
        r.locked    = e_lk;
        r.mismatch  = e_mm;
        r.lost_lock = e_ll;
        r.lockup    = exp_lockup;
        r.err       = exp_err;
        sb.push_back(r);
        if (en) gen = ud ? g_dn(gen) : g_up(gen);
    endtask

    task automatic rst_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset      = 1'b0;
            enable     = 1'b0;
            up_down    = 1'b0;
            count      = gen;
            exp_err    = '0;
            exp_lockup = 1'b0;
            sb.push_back('0);
        end
    endtask

    task automatic clean(input int n, input logic e_lk);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, e_lk, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        int    n;
        resp_t r;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check($sformatf("edge%0d", n), {12'd0, locked, mismatch, lost_lock, lockup, err_count},
                      {12'd0, r});
                n++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] v;
        reset = 1'b0; enable = 1'b0; up_down = 1'b0; count = '0;
        rst2 = 1'b0; en2 = 1'b0; ud2 = 1'b0; cnt2 = '0;
        gen = '0; exp_err = '0; exp_lockup = 1'b0;

        // Reset, then clean up-count from 0: lock on the 5th edge, two full wraps.
        rst_cyc(10);
        gen = 8'h00;
        clean(4, 1'b0);
        clean(506, 1'b1);

        // Direction reversal through 0 -> 80, then hold.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Two isolated misses: counted, lock retained.
        exp_err = 16'd1;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        clean(5, 1'b1);
        exp_err = 16'd2;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        clean(3, 1'b1);

        // Fresh lock, then three consecutive misses drop it.
        rst_cyc(1);
        clean(4, 1'b0);
        clean(5, 1'b1);
        exp_err = 16'd1;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        exp_err = 16'd2;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        exp_err = 16'd3;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
        // Reacquire; a miss while acquiring restarts the run and is not counted.
        clean(2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        clean(3, 1'b0);
        clean(4, 1'b1);

        // All-ones sample sets sticky lockup; reload back to a legal state.
        exp_err = 16'd4;
        exp_lockup = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        exp_err = 16'd5;
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        clean(10, 1'b1);

        // One-cycle reset mid-stream clears everything; relock follows.
        rst_cyc(1);
        clean(4, 1'b0);
        clean(6, 1'b1);
        for (int i = 0; i < 12; i++)
            drive((i % 3) != 0, i[0], 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);

        // Saturation of err_count on a second instance with MAX_ERR=15.
        @(negedge clk);
        rst2 = 1'b1;
        en2  = 1'b0;
        ud2  = 1'b0;
        cnt2 = 8'h11;
        v    = 8'h11;
        repeat (6) @(negedge clk);
        check("sat_lock", locked2, 1'b1);
        for (int b = 0; b < 4681; b++) begin
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                v = (v == 8'h11) ? 8'h22 : 8'h11;
                cnt2 = v;
            end
            @(negedge clk);
            cnt2 = v;
        end
        @(posedge clk);
        #1;
        check("sat_err_fffe", err2, 16'hFFFE);
        check("sat_locked_mid", locked2, 1'b1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            v = (v == 8'h11) ? 8'h22 : 8'h11;
            cnt2 = v;
        end
        @(negedge clk);
        cnt2 = v;
        @(posedge clk);
        #1;
        check("sat_err_ffff", err2, 16'hFFFF);
        @(negedge clk);
        v = (v == 8'h11) ? 8'h22 : 8'h11;
        cnt2 = v;
        @(posedge clk);
        #1;
        check("sat_mismatch", mismatch2, 1'b1);
        check("sat_hold", err2, 16'hFFFF);
        check("sat_locked_end", locked2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
